// File: rtl/burst_line_adapter.sv
// Adapts single-shot cache line requests to a beat-serial burst memory port.
// Optional BURST_ADAPTER_RADDR_CHECK_EN: drop read beats whose return address mismatches, flag err.
//
// state   | meaning
// IDLE    | waiting for a line read/write request
// RD_REQ  | issuing burst read command until memory accepts it
// RD_DATA | collecting BEATS return beats into the line buffer
// WR_DATA | presenting write beats, advancing on each accepted beat
// RESP    | one-cycle completion pulse to the requester
module burst_line_adapter #(
    parameter int ADDR_W = 32,
    parameter int BEAT_W = 64,
    parameter int BEATS  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_W-1:0]        dfp_addr,
    input  logic                     dfp_read,
    input  logic                     dfp_write,
    input  logic [BEAT_W*BEATS-1:0]  dfp_wdata,
    output logic [BEAT_W*BEATS-1:0]  dfp_rdata,
    output logic                     dfp_resp,
    output logic [ADDR_W-1:0]        bmem_addr,
    output logic                     bmem_read,
    output logic                     bmem_write,
    output logic [BEAT_W-1:0]        bmem_wdata,
    input  logic                     bmem_ready,
    input  logic [ADDR_W-1:0]        bmem_raddr,
    input  logic [BEAT_W-1:0]        bmem_rdata,
    input  logic                     bmem_rvalid,
    output logic                     err
);

    localparam int LINE_W = BEAT_W * BEATS;
    localparam int OFF_W  = $clog2(LINE_W / 8);
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_DATA = 3'd2,
        WR_DATA = 3'd3,
        RESP    = 3'd4
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   addr_aligned;
    logic [LINE_W-1:0]   wline_q;
    logic [LINE_W-1:0]   rbuf_q;
    logic [LINE_W-1:0]   rbuf_nx;
    logic [CNT_W-1:0]    cnt;
    logic [BEAT_W-1:0]   wbeat;
    logic                beat_ok;
    logic                unused_off;

    assign addr_aligned = {dfp_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
    assign unused_off   = ^dfp_addr[OFF_W-1:0];

`ifdef BURST_ADAPTER_RADDR_CHECK_EN
    logic raddr_match;
    logic err_q;

    assign raddr_match = (bmem_raddr == addr_q);
    assign beat_ok     = (state == RD_DATA) && bmem_rvalid && raddr_match;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if ((state == RD_DATA) && bmem_rvalid && !raddr_match) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    logic unused_raddr;

    assign unused_raddr = ^bmem_raddr;
    assign beat_ok      = (state == RD_DATA) && bmem_rvalid;
    assign err          = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (dfp_write) begin
                    state_nx = WR_DATA;
                end else if (dfp_read) begin
                    state_nx = RD_REQ;
                end
            end
            RD_REQ: begin
                if (bmem_ready) begin
                    state_nx = RD_DATA;
                end
            end
            RD_DATA: begin
                if (beat_ok && (cnt == LAST)) begin
                    state_nx = RESP;
                end
            end
            WR_DATA: begin
                if (bmem_ready && (cnt == LAST)) begin
                    state_nx = RESP;
                end
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        wbeat = '0;
        for (int i = 0; i < BEATS; i++) begin
            if (cnt == CNT_W'(i)) begin
                wbeat = wline_q[i*BEAT_W +: BEAT_W];
            end
        end
    end

    always_comb begin
        bmem_read  = 1'b0;
        bmem_write = 1'b0;
        bmem_wdata = '0;
        dfp_resp   = 1'b0;
        case (state)
            RD_REQ:  bmem_read = 1'b1;
            WR_DATA: begin
                bmem_write = 1'b1;
                bmem_wdata = wbeat;
            end
            RESP:    dfp_resp = 1'b1;
            default: ;
        endcase
    end

    assign bmem_addr = addr_q;

    // The final beat is merged combinationally so dfp_rdata updates only on a full line.
    always_comb begin
        rbuf_nx = rbuf_q;
        for (int i = 0; i < BEATS; i++) begin
            if (cnt == CNT_W'(i)) begin
                rbuf_nx[i*BEAT_W +: BEAT_W] = bmem_rdata;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q    <= '0;
            wline_q   <= '0;
            rbuf_q    <= '0;
            dfp_rdata <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (dfp_write) begin
                        addr_q  <= addr_aligned;
                        wline_q <= dfp_wdata;
                    end else if (dfp_read) begin
                        addr_q <= addr_aligned;
                    end
                end
                RD_REQ: cnt <= '0;
                RD_DATA: begin
                    if (beat_ok) begin
                        rbuf_q <= rbuf_nx;
                        cnt    <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            dfp_rdata <= rbuf_nx;
                        end
                    end
                end
                WR_DATA: begin
                    if (bmem_ready) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_burst_line_adapter.sv
// Directed bench for burst_line_adapter: table-driven read/write bursts plus reset,
// stray-beat and return-address corner sequences.
module tb_burst_line_adapter;

    logic         clk;
    logic         rst;
    logic [31:0]  dfp_addr;
    logic         dfp_read;
    logic         dfp_write;
    logic [255:0] dfp_wdata;
    logic [255:0] dfp_rdata;
    logic         dfp_resp;
    logic [31:0]  bmem_addr;
    logic         bmem_read;
    logic         bmem_write;
    logic [63:0]  bmem_wdata;
    logic         bmem_ready;
    logic [31:0]  bmem_raddr;
    logic [63:0]  bmem_rdata;
    logic         bmem_rvalid;
    logic         err;

    int n_cmp = 0;
    int n_bad = 0;

    burst_line_adapter #(.ADDR_W(32), .BEAT_W(64), .BEATS(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .dfp_addr    (dfp_addr),
        .dfp_read    (dfp_read),
        .dfp_write   (dfp_write),
        .dfp_wdata   (dfp_wdata),
        .dfp_rdata   (dfp_rdata),
        .dfp_resp    (dfp_resp),
        .bmem_addr   (bmem_addr),
        .bmem_read   (bmem_read),
        .bmem_write  (bmem_write),
        .bmem_wdata  (bmem_wdata),
        .bmem_ready  (bmem_ready),
        .bmem_raddr  (bmem_raddr),
        .bmem_rdata  (bmem_rdata),
        .bmem_rvalid (bmem_rvalid),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [31:0]       addr;
        logic [31:0]       exp_addr;
        logic [3:0][63:0]  beats;      // {beat3, beat2, beat1, beat0}
        int                gap;
        int                exp_lat;
        logic [255:0]      exp_line;
    } rd_vec_t;

    typedef struct {
        logic [31:0]       addr;
        logic [31:0]       exp_addr;
        logic [255:0]      wdata;
        logic [3:0][63:0]  exp_beats;  // {beat3, beat2, beat1, beat0}
        int                ready_low;
        bit                also_read;
        int                exp_lat;
    } wr_vec_t;

    rd_vec_t rv [3];
    wr_vec_t wv [2];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_read(input string tag, input logic [31:0] a, input logic [31:0] exp_addr,
                           input logic [31:0] raddr, input logic [3:0][63:0] beats, input int gap,
                           input bit bad, input int exp_lat, input logic [255:0] exp_line);
        int cyc;
        int lat;
        bit found;
        @(negedge clk);
        dfp_addr = a;
        dfp_read = 1'b1;
        bmem_ready = 1'b1;
        cyc = 0;
        @(negedge clk); cyc++;
        chk({tag, "_cmd"}, bmem_read, 1'b1);
        chk({tag, "_addr"}, bmem_addr, exp_addr);
        chk({tag, "_nowr"}, bmem_write, 1'b0);
        @(negedge clk); cyc++;
        chk({tag, "_rd_drop"}, bmem_read, 1'b0);
        if (bad) begin
            bmem_rvalid = 1'b1;
            bmem_raddr  = 32'h0000_2000;
            bmem_rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
            @(negedge clk); cyc++;
            chk({tag, "_err_set"}, err, 1'b1);
        end
        for (int k = 0; k < 4; k++) begin
            for (int g = 0; g < gap; g++) begin
                bmem_rvalid = 1'b0;
                @(negedge clk); cyc++;
            end
            bmem_rvalid = 1'b1;
            bmem_raddr  = raddr;
            bmem_rdata  = beats[k];
            @(negedge clk); cyc++;
        end
        bmem_rvalid = 1'b0;
        found = 1'b0;
        lat = 99;
        for (int t = 0; t < 3 && !found; t++) begin
            if (dfp_resp) begin
                found = 1'b1;
                lat = cyc;
            end else begin
                @(negedge clk); cyc++;
            end
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_line"}, dfp_rdata, exp_line);
        dfp_read = 1'b0;
        @(negedge clk);
        chk({tag, "_resp_1cyc"}, dfp_resp, 1'b0);
    endtask

    task automatic do_write(input string tag, input wr_vec_t v);
        int cyc;
        int lat;
        int k;
        bit found;
        @(negedge clk);
        dfp_addr  = v.addr;
        dfp_wdata = v.wdata;
        dfp_write = 1'b1;
        dfp_read  = v.also_read;
        cyc = 0;
        k = 0;
        @(negedge clk); cyc++;
        chk({tag, "_addr"}, bmem_addr, v.exp_addr);
        for (int it = 0; it < 4 + v.ready_low; it++) begin
            chk({tag, "_wr"}, bmem_write, 1'b1);
            chk({tag, "_nord"}, bmem_read, 1'b0);
            chk({tag, "_beat"}, bmem_wdata, v.exp_beats[k]);
            if (it < v.ready_low) begin
                bmem_ready = 1'b0;
            end else begin
                bmem_ready = 1'b1;
                k++;
            end
            @(negedge clk); cyc++;
        end
        bmem_ready = 1'b1;
        found = 1'b0;
        lat = 99;
        for (int t = 0; t < 3 && !found; t++) begin
            if (dfp_resp) begin
                found = 1'b1;
                lat = cyc;
            end else begin
                @(negedge clk); cyc++;
            end
        end
        chk({tag, "_lat"}, lat, v.exp_lat);
        chk({tag, "_wr_done"}, bmem_write, 1'b0);
        dfp_write = 1'b0;
        dfp_read  = 1'b0;
        @(negedge clk);
        chk({tag, "_resp_1cyc"}, dfp_resp, 1'b0);
        chk({tag, "_idle_nord"}, bmem_read, 1'b0);
    endtask

    initial begin
        rv[0] = '{addr: 32'h0000_1234, exp_addr: 32'h0000_1220,
                  beats: {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                          64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
                  gap: 0, exp_lat: 6,
                  exp_line: 256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111};
        rv[1] = '{addr: 32'h0000_FFFF, exp_addr: 32'h0000_FFE0,
                  beats: {64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000,
                          64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF},
                  gap: 2, exp_lat: 14,
                  exp_line: 256'hFFFFFFFFFFFFFFFF_0000000000000000_FEDCBA9876543210_0123456789ABCDEF};
        rv[2] = '{addr: 32'hFFFF_FFFF, exp_addr: 32'hFFFF_FFE0,
                  beats: {64'h0000_0000_0000_0002, 64'h0000_0000_0000_0001,
                          64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555},
                  gap: 1, exp_lat: 10,
                  exp_line: 256'h0000000000000002_0000000000000001_AAAAAAAAAAAAAAAA_5555555555555555};
        wv[0] = '{addr: 32'h0000_0040, exp_addr: 32'h0000_0040,
                  wdata: 256'hDDDDDDDDDDDDDDDD_CCCCCCCCCCCCCCCC_BBBBBBBBBBBBBBBB_AAAAAAAAAAAAAAAA,
                  exp_beats: {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                              64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA},
                  ready_low: 2, also_read: 1'b0, exp_lat: 7};
        wv[1] = '{addr: 32'h0001_0065, exp_addr: 32'h0001_0060,
                  wdata: 256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111,
                  exp_beats: {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
                  ready_low: 0, also_read: 1'b1, exp_lat: 5};

        rst = 1'b1;
        dfp_addr = '0; dfp_read = 1'b0; dfp_write = 1'b0; dfp_wdata = '0;
        bmem_ready = 1'b1; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 1'b0;
        #2;
        chk("rst_rdata", dfp_rdata, '0);
        chk("rst_resp", dfp_resp, 1'b0);
        chk("rst_read", bmem_read, 1'b0);
        chk("rst_write", bmem_write, 1'b0);
        chk("rst_addr", bmem_addr, '0);
        chk("rst_wdata", bmem_wdata, '0);
        chk("rst_err", err, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 3; i++) begin
            do_read($sformatf("rd%0d", i), rv[i].addr, rv[i].exp_addr, rv[i].exp_addr,
                    rv[i].beats, rv[i].gap, 1'b0, rv[i].exp_lat, rv[i].exp_line);
        end
        chk("err_after_reads", err, 1'b0);

        for (int i = 0; i < 2; i++) begin
            do_write($sformatf("wr%0d", i), wv[i]);
        end
        chk("rdata_kept_over_writes", dfp_rdata, rv[2].exp_line);

        // Stray beats in IDLE must not disturb the held line.
        @(negedge clk);
        bmem_rvalid = 1'b1; bmem_rdata = 64'h9999_9999_9999_9999; bmem_raddr = rv[2].exp_addr;
        @(negedge clk);
        bmem_rvalid = 1'b0;
        @(negedge clk);
        chk("idle_stray_rdata", dfp_rdata, rv[2].exp_line);
        chk("idle_stray_resp", dfp_resp, 1'b0);

        // Reset after the second beat of a read, then stray beats.
        dfp_addr = 32'h0000_1234; dfp_read = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bmem_raddr = 32'h0000_1220;
        bmem_rvalid = 1'b1; bmem_rdata = 64'h1111_1111_1111_1111;
        @(negedge clk);
        bmem_rdata = 64'h2222_2222_2222_2222;
        @(negedge clk);
        bmem_rvalid = 1'b0;
        rst = 1'b1;
        dfp_read = 1'b0;
        #1;
        chk("midrst_rdata", dfp_rdata, '0);
        chk("midrst_resp", dfp_resp, 1'b0);
        chk("midrst_read", bmem_read, 1'b0);
        chk("midrst_addr", bmem_addr, '0);
        @(negedge clk);
        rst = 1'b0;
        for (int s = 0; s < 2; s++) begin
            bmem_rvalid = 1'b1; bmem_rdata = 64'h3333_3333_3333_3333;
            @(negedge clk);
            chk("late_beat_resp", dfp_resp, 1'b0);
            chk("late_beat_rdata", dfp_rdata, '0);
            chk("late_beat_read", bmem_read, 1'b0);
        end
        bmem_rvalid = 1'b0;
        @(negedge clk);
        chk("post_late_rdata", dfp_rdata, '0);

`ifdef BURST_ADAPTER_RADDR_CHECK_EN
        do_read("rdchk", rv[0].addr, rv[0].exp_addr, rv[0].exp_addr, rv[0].beats, 0, 1'b1, 7,
                rv[0].exp_line);
        chk("err_sticky", err, 1'b1);
        do_read("rdchk2", rv[2].addr, rv[2].exp_addr, rv[2].exp_addr, rv[2].beats, 0, 1'b0, 6,
                rv[2].exp_line);
        chk("err_sticky2", err, 1'b1);
`else
        do_read("rdnochk", rv[0].addr, rv[0].exp_addr, 32'h0000_2000, rv[0].beats, 0, 1'b0, 6,
                rv[0].exp_line);
        chk("err_tied", err, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
